// File: rtl/maxpool_window_sched_if.sv
// rtl/maxpool_window_sched_if.sv - pixel stream, window and pooled-result bundle for maxpool_window_sched
interface maxpool_window_sched_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0]   pix_in;
  logic                    pix_valid;
  logic                    pix_ready;
  logic [9*DATA_WIDTH-1:0] win_data;
  logic                    win_valid;
  logic                    res_valid;
  logic [5:0]              res_row;
  logic [5:0]              res_col;

  modport master (
    output pix_in, pix_valid,
    input  pix_ready, win_data, win_valid, res_valid, res_row, res_col
  );

  modport slave (
    input  pix_in, pix_valid,
    output pix_ready, win_data, win_valid, res_valid, res_row, res_col
  );
endinterface

// File: rtl/maxpool_window_sched.sv
// rtl/maxpool_window_sched.sv - 3x3 max-pool window sequencer with line buffers and latency tracker
module maxpool_window_sched #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WIDTH  = 64,
  parameter int PIPE_LAT   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [6:0]                 cfg_width_i,
  input  logic [6:0]                 cfg_height_i,
  input  logic [1:0]                 cfg_stride_i,
  input  logic                       start_i,
  maxpool_window_sched_if.slave      bus,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       cfg_err_o
);
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;
  localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

  logic [1:0] state_q, state_d;
  logic [6:0] width_q, width_d, height_q, height_d;
  logic       stride2_q, stride2_d;
  logic [6:0] irow_q, irow_d, icol_q, icol_d;
  logic       cfg_err_q, cfg_err_d;
  logic       win_valid_q, win_valid_d;
  logic [5:0] win_row_q, win_row_d, win_col_q, win_col_d;

  logic [DATA_WIDTH-1:0] tap_q [9];
  logic [DATA_WIDTH-1:0] lb0_q [MAX_WIDTH];
  logic [DATA_WIDTH-1:0] lb1_q [MAX_WIDTH];
  logic                  trk_valid_q [PIPE_LAT];
  logic [5:0]            trk_row_q   [PIPE_LAT];
  logic [5:0]            trk_col_q   [PIPE_LAT];

  logic          accept;
  logic          cfg_ok;
  logic          win_hit;
  logic          last_pix;
  logic          pending;
  logic [6:0]    irow_m2, icol_m2;
  logic [AW-1:0] lb_addr;

  assign accept   = (state_q == ST_STREAM) && bus.pix_valid;
  assign cfg_ok   = (cfg_width_i >= 7'd3) && (cfg_width_i <= 7'(MAX_WIDTH)) &&
                    (cfg_height_i >= 7'd3) && (cfg_height_i <= 7'd64) &&
                    ((cfg_stride_i == 2'd1) || (cfg_stride_i == 2'd2));
  assign irow_m2  = irow_q - 7'd2;
  assign icol_m2  = icol_q - 7'd2;
  // With stride 2, (n-2) mod 2 == 0 reduces to the low bit of n-2.
  assign win_hit  = (irow_q >= 7'd2) && (icol_q >= 7'd2) &&
                    (!stride2_q || (!irow_m2[0] && !icol_m2[0]));
  assign last_pix = (irow_q == height_q - 7'd1) && (icol_q == width_q - 7'd1);
  assign lb_addr  = icol_q[AW-1:0];

  // The frame is finished once nothing is left ahead of the tracker's output stage.
  always_comb begin
    pending = win_valid_q;
    for (int i = 0; i < PIPE_LAT - 1; i++) begin
      pending = pending | trk_valid_q[i];
    end
  end

  always_comb begin
    state_d     = state_q;
    width_d     = width_q;
    height_d    = height_q;
    stride2_d   = stride2_q;
    irow_d      = irow_q;
    icol_d      = icol_q;
    cfg_err_d   = 1'b0;
    win_valid_d = 1'b0;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (cfg_ok) begin
            width_d   = cfg_width_i;
            height_d  = cfg_height_i;
            stride2_d = (cfg_stride_i == 2'd2);
            irow_d    = 7'd0;
            icol_d    = 7'd0;
            state_d   = ST_STREAM;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_STREAM: begin
        if (accept) begin
          win_valid_d = win_hit;
          win_row_d   = stride2_q ? irow_m2[6:1] : irow_m2[5:0];
          win_col_d   = stride2_q ? icol_m2[6:1] : icol_m2[5:0];
          if (last_pix) begin
            state_d = ST_DRAIN;
          end else if (icol_q == width_q - 7'd1) begin
            icol_d = 7'd0;
            irow_d = irow_q + 7'd1;
          end else begin
            icol_d = icol_q + 7'd1;
          end
        end
      end
      ST_DRAIN: begin
        if (!pending) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      width_q     <= 7'd0;
      height_q    <= 7'd0;
      stride2_q   <= 1'b0;
      irow_q      <= 7'd0;
      icol_q      <= 7'd0;
      cfg_err_q   <= 1'b0;
      win_valid_q <= 1'b0;
      win_row_q   <= 6'd0;
      win_col_q   <= 6'd0;
      for (int k = 0; k < 9; k++) begin
        tap_q[k] <= '0;
      end
      for (int i = 0; i < PIPE_LAT; i++) begin
        trk_valid_q[i] <= 1'b0;
        trk_row_q[i]   <= 6'd0;
        trk_col_q[i]   <= 6'd0;
      end
    end else begin
      state_q     <= state_d;
      width_q     <= width_d;
      height_q    <= height_d;
      stride2_q   <= stride2_d;
      irow_q      <= irow_d;
      icol_q      <= icol_d;
      cfg_err_q   <= cfg_err_d;
      win_valid_q <= win_valid_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
      if (accept) begin
        tap_q[0] <= tap_q[1];
        tap_q[1] <= tap_q[2];
        tap_q[2] <= lb1_q[lb_addr];
        tap_q[3] <= tap_q[4];
        tap_q[4] <= tap_q[5];
        tap_q[5] <= lb0_q[lb_addr];
        tap_q[6] <= tap_q[7];
        tap_q[7] <= tap_q[8];
        tap_q[8] <= bus.pix_in;
      end
      trk_valid_q[0] <= win_valid_q;
      trk_row_q[0]   <= win_row_q;
      trk_col_q[0]   <= win_col_q;
      for (int i = 1; i < PIPE_LAT; i++) begin
        trk_valid_q[i] <= trk_valid_q[i-1];
        trk_row_q[i]   <= trk_row_q[i-1];
        trk_col_q[i]   <= trk_col_q[i-1];
      end
    end
  end

  // Line buffers are indexed by column, so each entry holds the pixel one row above.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1_q[lb_addr] <= lb0_q[lb_addr];
      lb0_q[lb_addr] <= bus.pix_in;
    end
  end

  for (genvar k = 0; k < 9; k++) begin : g_win
    assign bus.win_data[DATA_WIDTH*k +: DATA_WIDTH] = tap_q[k];
  end

  assign bus.pix_ready = (state_q == ST_STREAM);
  assign bus.win_valid = win_valid_q;
  assign bus.res_valid = trk_valid_q[PIPE_LAT-1];
  assign bus.res_row   = trk_row_q[PIPE_LAT-1];
  assign bus.res_col   = trk_col_q[PIPE_LAT-1];
  assign busy_o        = (state_q == ST_STREAM) || (state_q == ST_DRAIN);
  assign done_o        = (state_q == ST_DONE);
  assign cfg_err_o     = cfg_err_q;
endmodule

// File: tb/tb_maxpool_window_sched.sv
// tb/tb_maxpool_window_sched.sv - scoreboard bench for maxpool_window_sched
module tb_maxpool_window_sched;
  localparam int DW  = 32;
  localparam int LAT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] cfg_width, cfg_height;
  logic [1:0] cfg_stride;
  logic       start;
  logic       busy, done, cfg_err;

  maxpool_window_sched_if #(.DATA_WIDTH(DW)) bus ();

  maxpool_window_sched #(.DATA_WIDTH(DW), .MAX_WIDTH(64), .PIPE_LAT(LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_width_i  (cfg_width),
    .cfg_height_i (cfg_height),
    .cfg_stride_i (cfg_stride),
    .start_i      (start),
    .bus          (bus),
    .busy_o       (busy),
    .done_o       (done),
    .cfg_err_o    (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              cyc;
    logic [9*DW-1:0] data;
    int              r;
    int              c;
  } win_exp_t;

  typedef struct {
    int cyc;
    int r;
    int c;
  } res_exp_t;

  win_exp_t win_q[$];
  res_exp_t res_q[$];
  int tab_pix[$];
  int tab_r[$];
  int tab_c[$];

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int last_res_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_w(input string name, input logic [9*DW-1:0] act, input logic [9*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a window or result.
  always @(negedge clk) begin
    if (bus.win_valid === 1'b1) begin
      if (win_q.size() == 0) begin
        chk("win_unexpected", 1, 0);
      end else begin
        win_exp_t e;
        e = win_q.pop_front();
        chk("win_cycle", cyc, e.cyc);
        chk_w("win_taps", bus.win_data, e.data);
      end
    end
    if (bus.res_valid === 1'b1) begin
      if (res_q.size() == 0) begin
        chk("res_unexpected", 1, 0);
      end else begin
        res_exp_t e;
        e = res_q.pop_front();
        chk("res_cycle", cyc, e.cyc);
        chk("res_row", bus.res_row, e.r);
        chk("res_col", bus.res_col, e.c);
        last_res_cyc = cyc;
      end
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic add_exp(input int p, input int r, input int c);
    tab_pix.push_back(p);
    tab_r.push_back(r);
    tab_c.push_back(c);
  endtask

  task automatic do_start(input int w, input int h, input int s);
    @(negedge clk);
    cfg_width  = 7'(w);
    cfg_height = 7'(h);
    cfg_stride = 2'(s);
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("ready_after_start", bus.pix_ready, 1);
  endtask

  // Drives pixels 0..n-1 starting at the current negedge; value of pixel i is i.
  task automatic drive_pixels(input int w, input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      if (gap) begin
        bus.pix_valid = 1'b0;
        @(negedge clk);
      end
      bus.pix_valid = 1'b1;
      bus.pix_in    = DW'(i);
      if (i == 0) chk("ready_first_pixel", bus.pix_ready, 1);
      for (int t = 0; t < tab_pix.size(); t++) begin
        if (tab_pix[t] == i) begin
          win_exp_t we;
          res_exp_t re;
          int qr, qc;
          qr = i / w;
          qc = i % w;
          we.cyc  = cyc + 1;
          we.r    = tab_r[t];
          we.c    = tab_c[t];
          we.data = '0;
          for (int k = 0; k < 9; k++) begin
            we.data[DW*k +: DW] = DW'((qr - 2 + k / 3) * w + (qc - 2 + k % 3));
          end
          re.cyc = we.cyc + LAT;
          re.r   = tab_r[t];
          re.c   = tab_c[t];
          win_q.push_back(we);
          res_q.push_back(re);
        end
      end
    end
    @(negedge clk);
    bus.pix_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit got;
    got = 1'b0;
    for (int t = 0; t < 60 && !got; t++) begin
      if (done === 1'b1) got = 1'b1;
      else @(negedge clk);
    end
    chk("done_seen", got, 1);
    if (got) begin
      chk("done_after_last_res", cyc, last_res_cyc + 1);
      chk("busy_low_in_done", busy, 0);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
    end
    chk("win_queue_empty", win_q.size(), 0);
    chk("res_queue_empty", res_q.size(), 0);
    tab_pix.delete();
    tab_r.delete();
    tab_c.delete();
    win_q.delete();
    res_q.delete();
  endtask

  task automatic frame_4x4(input bit gap);
    add_exp(10, 0, 0);
    add_exp(11, 0, 1);
    add_exp(14, 1, 0);
    add_exp(15, 1, 1);
    do_start(4, 4, 1);
    drive_pixels(4, 16, gap);
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9*DW-1:0] first_taps;
    int d0;
    rst           = 1'b1;
    start         = 1'b0;
    cfg_width     = 7'd0;
    cfg_height    = 7'd0;
    cfg_stride    = 2'd0;
    bus.pix_in    = '0;
    bus.pix_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pix_ready", bus.pix_ready, 0);
    chk("rst_win_valid", bus.win_valid, 0);
    chk_w("rst_win_data", bus.win_data, '0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_row", bus.res_row, 0);
    chk("rst_res_col", bus.res_col, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cfg_err", cfg_err, 0);
    rst = 1'b0;

    // 4x4 stride 1; first window taps are pixels 0,1,2,4,5,6,8,9,10
    first_taps = {DW'(10), DW'(9), DW'(8), DW'(6), DW'(5), DW'(4), DW'(2), DW'(1), DW'(0)};
    add_exp(10, 0, 0);
    add_exp(11, 0, 1);
    add_exp(14, 1, 0);
    add_exp(15, 1, 1);
    do_start(4, 4, 1);
    drive_pixels(4, 16, 1'b0);
    chk_w("first_win_taps_vs_table", win_q.size() > 0 ? first_taps : '1, first_taps);
    wait_done();

    // 5x5 stride 2; last window taps 12,13,14,17,18,19,22,23,24
    add_exp(12, 0, 0);
    add_exp(14, 0, 1);
    add_exp(22, 1, 0);
    add_exp(24, 1, 1);
    do_start(5, 5, 2);
    drive_pixels(5, 25, 1'b0);
    wait_done();

    // 6x3 stride 2: trailing column 5 never issues
    add_exp(14, 0, 0);
    add_exp(16, 0, 1);
    do_start(6, 3, 2);
    drive_pixels(6, 18, 1'b0);
    wait_done();

    // 4x4 with a gap before every pixel
    frame_4x4(1'b1);

    // Illegal width rejected, then a legal frame accepted
    @(negedge clk);
    cfg_width  = 7'd2;
    cfg_height = 7'd4;
    cfg_stride = 2'd1;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("cfg_err_pulse", cfg_err, 1);
    chk("cfg_err_busy", busy, 0);
    chk("cfg_err_ready", bus.pix_ready, 0);
    @(negedge clk);
    chk("cfg_err_one_cycle", cfg_err, 0);
    chk("cfg_err_still_idle", busy, 0);
    frame_4x4(1'b0);

    // Reset after 7 pixels: outputs clear, no done, then a clean frame
    do_start(4, 4, 1);
    drive_pixels(4, 7, 1'b0);
    d0  = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", bus.pix_ready, 0);
    chk("midrst_win_valid", bus.win_valid, 0);
    chk_w("midrst_win_data", bus.win_data, '0);
    chk("midrst_res_valid", bus.res_valid, 0);
    chk("midrst_done", done, 0);
    repeat (12) @(negedge clk);
    chk("midrst_no_done", done_cnt, d0);
    frame_4x4(1'b0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/maxpool_window_sched.md
# maxpool_window_sched

Sequencer for the 3x3 max-pooling datapath. Accepts a single-channel feature map as a raster-order 32-bit pixel stream and buffers two previous rows internally. It issues one 9-tap window per pooling output position, honouring the configured stride, to the fixed-latency max-finder. It also tracks the max-finder's latency so that each pooled result can be tagged with its output coordinates and the end of the frame can be signalled.

## Interface
Parameters:
- DATA_WIDTH, 32, pixel width in bits.
- MAX_WIDTH, 64, maximum row length in pixels; sets the depth of each of the two line buffers.
- PIPE_LAT, 4, max-finder latency in cycles, from window valid to result valid.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_width  in  7  frame width W; sampled on an accepted start.
- cfg_height  in  7  frame height H; sampled on an accepted start.
- cfg_stride  in  2  pooling stride S; legal values are 1 and 2; sampled on an accepted start.
- start  in  1  single-cycle frame start request.
- pix_in  in  DATA_WIDTH  input pixel.
- pix_valid  in  1  pix_in is valid this cycle.
- pix_ready  out  1  block can accept a pixel this cycle.
- win_data  out  9*DATA_WIDTH  window taps; tap k = 3*r + c sits at bits [DATA_WIDTH*k +: DATA_WIDTH]. r=0 is the oldest row, c=0 is the oldest column.
- win_valid  out  1  win_data holds a complete window; drives the max-finder's valid input.
- res_valid  out  1  max-finder output is valid this cycle.
- res_row, res_col  out  6 each  output coordinates of the current result.
- busy  out  1  a frame is in progress.
- done  out  1  one-cycle pulse after the last result of the frame.
- cfg_err  out  1  one-cycle pulse when a start is rejected.

## Operation
- State IDLE:
  - start with a legal configuration latches W, H and S, clears the pixel counters, and moves to STREAM.
  - The configuration is legal when 3 <= W <= MAX_WIDTH, 3 <= H <= 64, and S is 1 or 2.
  - start with an illegal configuration pulses cfg_err the next cycle and stays in IDLE.
- State STREAM:
  - pix_ready = 1.
  - A pixel is accepted when pix_valid && pix_ready. Input row and column counters (irow, icol) advance in raster order.
  - Each accepted pixel is shifted into a 3x3 tap register. Column 2 of each tap row is loaded from line buffer 1, line buffer 0, and pix_in respectively. The line buffers shift on acceptance only.
  - A window is issued (win_valid next cycle) when irow >= 2, icol >= 2, (irow-2) mod S == 0 and (icol-2) mod S == 0.
  - Output coordinates are ((irow-2)/S, (icol-2)/S). The output frame is OW x OH, with OW = (W-3)/S + 1 and OH = (H-3)/S + 1, using floor division.
  - Trailing rows and columns that cannot start a full stride step are consumed but never issue a window.
  - The pixel at (H-1, W-1) moves the block to DRAIN.
- State DRAIN:
  - pix_ready = 0.
  - The block waits until the last issued window has left the latency tracker, then moves to DONE.
- State DONE: done = 1 for one cycle, then the block returns to IDLE.
- Latency tracker: a PIPE_LAT-deep shift register carries a valid bit and coordinates. res_valid and res_row/res_col are its output stage.
- start while busy is ignored; no cfg_err is raised.

## Timing
- Reset values: pix_ready = 0, win_valid = 0, win_data = 0, res_valid = 0, res_row = 0, res_col = 0, busy = 0, done = 0, cfg_err = 0, state = IDLE, tracker cleared.
- Line-buffer contents are not cleared by reset; each frame overwrites them before use.
- busy rises the cycle after an accepted start. It stays high through STREAM and DRAIN and falls in the DONE cycle.
- pix_ready is 1 from the first STREAM cycle; the first pixel can be accepted the cycle after start.
- win_valid is registered: it is high exactly one cycle, the cycle after the completing pixel is accepted.
- Back-to-back pixels give back-to-back windows when S = 1.
- Gaps in pix_valid only stall the block; no window is issued and no state advances during a gap.
- res_valid is win_valid delayed exactly PIPE_LAT cycles, with the coordinates carried alongside.
- done is asserted the cycle after the final res_valid.
- rst mid-frame returns the block to IDLE on the next edge. The tracker is flushed, so no res_valid or done follows.

## Test plan
- W=4, H=4, S=1, pixel value = 4*row + col, no gaps:
  - Exactly 4 windows.
  - The first win_valid comes one cycle after pixel 10, with taps 0,1,2,4,5,6,8,9,10.
  - res coordinates are (0,0), (0,1), (1,0), (1,1); each res_valid follows its win_valid by 4 cycles.
  - done comes one cycle after the 4th res_valid.
- W=5, H=5, S=2:
  - Windows issue after pixels 12, 14, 22 and 24.
  - The last window's taps are 12,13,14,17,18,19,22,23,24.
- W=6, H=3, S=2 (trailing column):
  - OW = 2 and OH = 1; windows issue after pixels 14 and 16.
  - Pixel 17 produces no window.
- Same 4x4 frame with pix_valid low on every other cycle:
  - Identical windows and taps, stretched in time.
  - Windows never issue during a gap.
- cfg_width = 2, start:
  - cfg_err pulses for one cycle, busy stays 0 and pix_ready stays 0.
  - A following legal start is accepted.
- rst asserted after 7 pixels of a 4x4 frame:
  - All outputs are 0 on the next cycle and there is no done.
  - A new 4x4 frame then produces the correct 4 windows.
